// File: rtl/sha512_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha512_pkg
// Description : Types and constants shared by the SHA-512 padder and the
//               chunk compressor: word/chunk types, length field width,
//               padder state encoding and the byte-count clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sha512_pkg;

    localparam int WORD_W      = 64;
    localparam int CHUNK_WORDS = 16;
    localparam int LEN_FIELD_W = 128;

    typedef logic [WORD_W-1:0] word_t;

    // Ascending outer range puts word 0 in the most significant 64 bits.
    typedef logic [0:CHUNK_WORDS-1][WORD_W-1:0] chunk_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_SEND  = 2'd2,
        ST_EXTRA = 2'd3
    } pad_state_t;

    localparam word_t PAD_WORD = 64'h8000_0000_0000_0000;

    // Byte counts above 8 on a final word mean a full word.
    function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha512_padder_if.sv
`default_nettype none
// ============================================================================
// Module      : sha512_padder_if
// Description : Message-word input and chunk output handshakes of the padder.
//               slave  : padder side (takes words, produces chunks)
//               master : producer/consumer side
//   in_valid/in_ready/in_data/in_last/in_nbytes : message word stream
//   chunk_valid/chunk_ready/chunk/chunk_last    : 1024-bit block stream
// Revision    : 1.0 - initial release
// ============================================================================
interface sha512_padder_if;
    import sha512_pkg::*;

    logic       in_valid;
    logic       in_ready;
    word_t      in_data;
    logic       in_last;
    logic [3:0] in_nbytes;
    logic       chunk_valid;
    logic       chunk_ready;
    chunk_t     chunk;
    logic       chunk_last;

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, chunk_ready,
        output in_ready, chunk_valid, chunk, chunk_last
    );

    modport master (
        output in_valid, in_data, in_last, in_nbytes, chunk_ready,
        input  in_ready, chunk_valid, chunk, chunk_last
    );

endinterface
`default_nettype wire

// File: rtl/sha512_pad_mask.sv
`default_nettype none
// ============================================================================
// Module      : sha512_pad_mask
// Description : Combinational final-word masker. For a last word, bytes past
//               the first nbytes are cleared and 0x80 is written right after
//               the message bytes (nothing inserted for a full word).
//   word_i   : message word, first byte in [63:56]
//   nbytes_i : valid bytes (values above 8 mean 8)
//   last_i   : word is the final message word
//   word_o   : masked word
// Revision    : 1.0 - initial release
// ============================================================================
module sha512_pad_mask
    import sha512_pkg::*;
(
    input  word_t      word_i,
    input  logic [3:0] nbytes_i,
    input  logic       last_i,
    output word_t      word_o
);

    logic [3:0] n_w;

    assign n_w = clamp_nbytes(nbytes_i);

    always_comb begin
        word_o = word_i;
        if (last_i) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) == n_w) begin
                    word_o[63-8*b -: 8] = 8'h80;
                end else if (4'(b) > n_w) begin
                    word_o[63-8*b -: 8] = 8'h00;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha512_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha512_padder
// Description : SHA-512 message padder. Collects big-endian 64-bit words into
//               1024-bit chunks, appends 0x80, zero fill and the 128-bit bit
//               length, adding an extra chunk when the length does not fit.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : sha512_padder_if.slave (word input, chunk output)
// Revision    : 1.0 - initial release
// ============================================================================
module sha512_padder
    import sha512_pkg::*;
#(
    parameter int LEN_W = 128
)(
    input  logic            clk,
    input  logic            reset,
    sha512_padder_if.slave  bus
);

    pad_state_t        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        n_q, n_d;
    logic [LEN_W-1:0]  len_q, len_d;
    chunk_t            chunk_q, chunk_d;
    logic              last_q, last_d;
    logic              need_extra_q, need_extra_d;
    logic              need_80_q, need_80_d;

    word_t             masked_w;
    logic [3:0]        nbytes_eff;
    logic              xfer;
    logic [7:0]        pad_pos;
    logic [127:0]      len_field;

    sha512_pad_mask u_mask (
        .word_i   (bus.in_data),
        .nbytes_i (bus.in_nbytes),
        .last_i   (bus.in_last),
        .word_o   (masked_w)
    );

    assign nbytes_eff = bus.in_last ? clamp_nbytes(bus.in_nbytes) : 4'd8;
    assign xfer       = bus.in_valid && bus.in_ready;
    assign len_field  = 128'(len_q);
    // Byte offset of the 0x80 marker within the current chunk (0..128).
    assign pad_pos    = {1'b0, k_q, 3'b000} + {4'b0000, n_q};

    assign bus.in_ready    = reset && (state_q == ST_FILL);
    assign bus.chunk_valid = reset && (state_q == ST_SEND);
    assign bus.chunk       = chunk_q;
    assign bus.chunk_last  = last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            idx_q        <= '0;
            k_q          <= '0;
            n_q          <= '0;
            len_q        <= '0;
            chunk_q      <= '0;
            last_q       <= 1'b0;
            need_extra_q <= 1'b0;
            need_80_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            k_q          <= k_d;
            n_q          <= n_d;
            len_q        <= len_d;
            chunk_q      <= chunk_d;
            last_q       <= last_d;
            need_extra_q <= need_extra_d;
            need_80_q    <= need_80_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        k_d          = k_q;
        n_d          = n_q;
        len_d        = len_q;
        chunk_d      = chunk_q;
        last_d       = last_q;
        need_extra_d = need_extra_q;
        need_80_d    = need_80_q;

        case (state_q)
            ST_FILL: begin
                if (xfer) begin
                    chunk_d[idx_q] = masked_w;
                    len_d          = len_q + LEN_W'({nbytes_eff, 3'b000});
                    if (bus.in_last) begin
                        k_d     = idx_q;
                        n_d     = nbytes_eff;
                        state_d = ST_PAD;
                    end else if (idx_q == 4'd15) begin
                        idx_d   = '0;
                        last_d  = 1'b0;
                        state_d = ST_SEND;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            ST_PAD: begin
                // Words after the last message word may hold data from an
                // earlier chunk of the same message, so clear them. A full
                // final word leaves the 0x80 marker for the following word.
                for (int j = 0; j < CHUNK_WORDS; j++) begin
                    if (4'(j) > k_q) begin
                        chunk_d[j] = '0;
                    end
                    if ((n_q == 4'd8) && (5'(j) == ({1'b0, k_q} + 5'd1))) begin
                        chunk_d[j] = PAD_WORD;
                    end
                end
                if (pad_pos <= 8'd111) begin
                    chunk_d[14]  = len_field[127:64];
                    chunk_d[15]  = len_field[63:0];
                    last_d       = 1'b1;
                    need_extra_d = 1'b0;
                end else begin
                    last_d       = 1'b0;
                    need_extra_d = 1'b1;
                    need_80_d    = (pad_pos == 8'd128);
                end
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (bus.chunk_ready) begin
                    if (last_q) begin
                        idx_d        = '0;
                        len_d        = '0;
                        last_d       = 1'b0;
                        need_extra_d = 1'b0;
                        need_80_d    = 1'b0;
                        state_d      = ST_FILL;
                    end else if (need_extra_q) begin
                        state_d = ST_EXTRA;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_EXTRA: begin
                chunk_d = '0;
                if (need_80_q) begin
                    chunk_d[0] = PAD_WORD;
                end
                chunk_d[14]  = len_field[127:64];
                chunk_d[15]  = len_field[63:0];
                last_d       = 1'b1;
                need_extra_d = 1'b0;
                state_d      = ST_SEND;
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sha512_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha512_padder
// Description : Self-checking bench for sha512_padder. A byte-level padding
//               model produces the expected chunk stream; a monitor compares
//               every valid cycle against it, and directed messages pin
//               specific padding words to literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha512_padder;
    import sha512_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sha512_padder_if bus();

    sha512_padder #(.LEN_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;
    int rdy_mode = 1;   // 0: hold low, 1: always high, 2: random
    bit gaps = 1'b0;

    logic [1023:0] exp_c[$];
    logic          exp_l[$];
    logic [1023:0] got_c[$];
    logic          got_l[$];
    logic [1023:0] mon_c;

    function automatic logic [63:0] wd(input logic [1023:0] c, input int j);
        return c[64*(15-j) +: 64];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_chunk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        int bad;
        checks++;
        if (got !== exp) begin
            errs++;
            bad = 0;
            for (int j = 15; j >= 0; j--) if (wd(got, j) !== wd(exp, j)) bad = j;
            $display("FAIL %s: word %0d got %h expected %h", name, bad, wd(got, bad), wd(exp, bad));
        end
    endtask

    // OR of a word range must be zero.
    task automatic chk_zero(input string name, input logic [1023:0] c, input int lo, input int hi);
        logic [63:0] acc;
        acc = '0;
        for (int j = lo; j <= hi; j++) acc = acc | wd(c, j);
        chk(name, acc, 64'h0);
    endtask

    task automatic push_blocks(input bq_t q, input bit final_is_last);
        logic [1023:0] c;
        int nb;
        nb = q.size() / 128;
        for (int b = 0; b < nb; b++) begin
            c = '0;
            for (int i = 0; i < 128; i++) c[1023-8*i -: 8] = q[128*b+i];
            exp_c.push_back(c);
            exp_l.push_back(final_is_last && (b == nb - 1));
        end
    endtask

    // Reference padding: message, 0x80, zeros to 112 mod 128, 128-bit length.
    task automatic model_push(input bq_t msg);
        bq_t q;
        logic [127:0] lb;
        q = msg;
        q.push_back(8'h80);
        while ((q.size() % 128) != 112) q.push_back(8'h00);
        lb = 128'(msg.size()) * 128'd8;
        for (int i = 15; i >= 0; i--) q.push_back(lb[8*i +: 8]);
        push_blocks(q, 1'b1);
    endtask

    // Called at a negedge; returns at the negedge after the word transfers.
    task automatic put_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int cnt;
        cnt = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.in_nbytes = nb;
        while (!bus.in_ready && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.in_ready) begin
            checks++;
            errs++;
            $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", cnt);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg);
        int L, nw, idx;
        logic [63:0] d;
        logic [3:0] nb;
        bit last;
        L  = msg.size();
        model_push(msg);
        nw = (L == 0) ? 1 : (L + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 8; b++) begin
                idx = 8*w + b;
                d[63-8*b -: 8] = (idx < L) ? msg[idx] : 8'($urandom);
            end
            last = (w == nw - 1);
            if (last) begin
                nb = 4'(L - 8*(nw - 1));
                if (nb == 4'd8) nb = 4'($urandom_range(8, 15));
            end else begin
                nb = 4'($urandom_range(0, 15));
            end
            put_word(d, last, nb);
            if (gaps && !last && ($urandom_range(0, 3) == 0)) @(negedge clk);
        end
    endtask

    function automatic bq_t rand_msg(input int L);
        bq_t q;
        for (int i = 0; i < L; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic wait_got(input string name, input int target, output bit ok);
        int cnt;
        cnt = 0;
        while (got_c.size() < target && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        ok = (got_c.size() >= target);
        chk({name, "_count"}, 64'(got_c.size() >= target), 64'd1);
    endtask

    task automatic do_abc(input string tag);
        bq_t m;
        int base;
        bit ok;
        m = {8'h61, 8'h62, 8'h63};
        base = got_c.size();
        send_msg(m);
        chk({tag, "_lat_pad"}, 64'(bus.chunk_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_lat_send"}, 64'(bus.chunk_valid), 64'd1);
        wait_got(tag, base + 1, ok);
        if (ok) begin
            chk({tag, "_w0"}, wd(got_c[base], 0), 64'h6162638000000000);
            chk_zero({tag, "_w1_14"}, got_c[base], 1, 14);
            chk({tag, "_w15"}, wd(got_c[base], 15), 64'h18);
            chk({tag, "_last"}, 64'(got_l[base]), 64'd1);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.chunk_ready = 1'b0;
            1:       bus.chunk_ready = 1'b1;
            default: bus.chunk_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Every valid cycle is checked against the head of the model queue,
    // which also proves the chunk holds still while stalled.
    always @(negedge clk) begin
        if (reset && bus.chunk_valid) begin
            mon_c = bus.chunk;
            if (exp_c.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_chunk: got a valid chunk, expected none");
            end else begin
                chk_chunk("model_chunk", mon_c, exp_c[0]);
                chk("model_last", 64'(bus.chunk_last), 64'(exp_l[0]));
                if (bus.chunk_ready) begin
                    void'(exp_c.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            if (bus.chunk_ready) begin
                got_c.push_back(mon_c);
                got_l.push_back(bus.chunk_last);
            end
        end
    end

    initial begin
        #5ms;
        errs++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        bq_t m;
        bq_t blk;
        int base, cnt;
        bit ok;
        logic [63:0] d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = '0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_chunk_valid", 64'(bus.chunk_valid), 64'd0);
        chk_chunk("rst_chunk", bus.chunk, '0);
        chk("rst_chunk_last", 64'(bus.chunk_last), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_chunk_valid", 64'(bus.chunk_valid), 64'd0);

        do_abc("abc");

        // Empty message
        m = {};
        base = got_c.size();
        send_msg(m);
        wait_got("empty", base + 1, ok);
        if (ok) begin
            chk("empty_w0", wd(got_c[base], 0), 64'h8000000000000000);
            chk_zero("empty_w1_15", got_c[base], 1, 15);
            chk("empty_last", 64'(got_l[base]), 64'd1);
        end

        // 111 bytes: length still fits in the same chunk
        m = rand_msg(111);
        base = got_c.size();
        send_msg(m);
        wait_got("b111", base + 1, ok);
        if (ok) begin
            chk("b111_w13_lo", 64'(wd(got_c[base], 13) & 64'hFF), 64'h80);
            chk("b111_w14", wd(got_c[base], 14), 64'h0);
            chk("b111_w15", wd(got_c[base], 15), 64'h378);
            chk("b111_last", 64'(got_l[base]), 64'd1);
        end

        // 112 bytes: marker fits, length spills to a second chunk
        m = rand_msg(112);
        base = got_c.size();
        send_msg(m);
        wait_got("b112", base + 2, ok);
        if (ok) begin
            chk("b112_A_w14", wd(got_c[base], 14), 64'h8000000000000000);
            chk("b112_A_w15", wd(got_c[base], 15), 64'h0);
            chk("b112_A_last", 64'(got_l[base]), 64'd0);
            chk_zero("b112_B_w0_14", got_c[base+1], 0, 14);
            chk("b112_B_w15", wd(got_c[base+1], 15), 64'h380);
            chk("b112_B_last", 64'(got_l[base+1]), 64'd1);
        end

        // 128 bytes: data fills chunk A, marker starts chunk B
        m = rand_msg(128);
        base = got_c.size();
        send_msg(m);
        wait_got("b128", base + 2, ok);
        if (ok) begin
            for (int b = 0; b < 8; b++) d[63-8*b -: 8] = m[120+b];
            chk("b128_A_w15", wd(got_c[base], 15), d);
            chk("b128_A_last", 64'(got_l[base]), 64'd0);
            chk("b128_B_w0", wd(got_c[base+1], 0), 64'h8000000000000000);
            chk_zero("b128_B_w1_14", got_c[base+1], 1, 14);
            chk("b128_B_w15", wd(got_c[base+1], 15), 64'h400);
            chk("b128_B_last", 64'(got_l[base+1]), 64'd1);
        end

        // Randomized lengths, gaps and back-pressure
        rdy_mode = 2;
        gaps = 1'b1;
        repeat (30) begin
            m = rand_msg($urandom_range(0, 300));
            send_msg(m);
        end
        cnt = 0;
        while (exp_c.size() != 0 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        chk("random_drained", 64'(exp_c.size()), 64'd0);

        // Stall a full data chunk, then reset in the middle of the message
        rdy_mode = 0;
        gaps = 1'b0;
        @(negedge clk);
        blk = rand_msg(128);
        push_blocks(blk, 1'b0);
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 8; b++) d[63-8*b -: 8] = blk[8*w+b];
            put_word(d, 1'b0, 4'($urandom_range(0, 15)));
        end
        chk("stall_valid", 64'(bus.chunk_valid), 64'd1);
        repeat (5) @(negedge clk);
        chk("stall_still_valid", 64'(bus.chunk_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_chunk_valid", 64'(bus.chunk_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        exp_c.delete();
        exp_l.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("after_rst_chunk_valid", 64'(bus.chunk_valid), 64'd0);
        chk("after_rst_in_ready", 64'(bus.in_ready), 64'd1);
        rdy_mode = 1;
        do_abc("abc2");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
